// File: rtl/pe_frame_controller_if.sv
// rtl/pe_frame_controller_if.sv - frame buffer and processing-element bus of the frame controller
interface pe_frame_controller_if #(
    parameter int NUM_PIXELS = 1,
    parameter int ADDR_W     = 4
);
    localparam int PW = 8 * NUM_PIXELS;

    logic [ADDR_W-1:0] mem_rd_addr;
    logic [PW-1:0]     mem_rd_r, mem_rd_g, mem_rd_b;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [PW-1:0]     mem_wr_r, mem_wr_g, mem_wr_b;

    logic [PW-1:0]     pe_red_in, pe_green_in, pe_blue_in;
    logic [7:0]        pe_red_exp, pe_green_exp, pe_blue_exp;
    logic [17:0]       pe_threshold;
    logic [7:0]        pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b;
    logic              Start_Sum, Start_BgRemoval, Ack;
    logic              pe_Qi, pe_Qsd, pe_Qbgd;
    logic [PW-1:0]     pe_red_sum, pe_green_sum, pe_blue_sum;
    logic [PW-1:0]     pe_red_out, pe_green_out, pe_blue_out;

    modport master (
        output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
        output pe_red_in, pe_green_in, pe_blue_in, pe_red_exp, pe_green_exp, pe_blue_exp,
        output pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b,
        output Start_Sum, Start_BgRemoval, Ack,
        input  mem_rd_r, mem_rd_g, mem_rd_b,
        input  pe_Qi, pe_Qsd, pe_Qbgd,
        input  pe_red_sum, pe_green_sum, pe_blue_sum,
        input  pe_red_out, pe_green_out, pe_blue_out
    );

    modport slave (
        input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
        input  pe_red_in, pe_green_in, pe_blue_in, pe_red_exp, pe_green_exp, pe_blue_exp,
        input  pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b,
        input  Start_Sum, Start_BgRemoval, Ack,
        output mem_rd_r, mem_rd_g, mem_rd_b,
        output pe_Qi, pe_Qsd, pe_Qbgd,
        output pe_red_sum, pe_green_sum, pe_blue_sum,
        output pe_red_out, pe_green_out, pe_blue_out
    );
endinterface

// File: rtl/pe_frame_controller.sv
// rtl/pe_frame_controller.sv - two-pass frame sequencer driving one processing element
module pe_frame_controller #(
    parameter int NUM_PIXELS = 1,
    parameter int NUM_CHUNKS = 16,
    parameter int ADDR_W     = 4,
    parameter int LOG2_TOTAL = 4,
    parameter int ACC_W      = 12,
    parameter int WAIT_LIMIT = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] threshold,
    input  logic [7:0]  desired_bg_r,
    input  logic [7:0]  desired_bg_g,
    input  logic [7:0]  desired_bg_b,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    pe_frame_controller_if.master bus
);
    localparam int PW   = 8 * NUM_PIXELS;
    localparam int WD_W = $clog2(WAIT_LIMIT) + 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_WAIT  = 4'd3;
    localparam logic [3:0] S_NEXT  = 4'd4;
    localparam logic [3:0] MEAN    = 4'd5;
    localparam logic [3:0] B_FETCH = 4'd6;
    localparam logic [3:0] B_LOAD  = 4'd7;
    localparam logic [3:0] B_WAIT  = 4'd8;
    localparam logic [3:0] B_NEXT  = 4'd9;
    localparam logic [3:0] FINISH  = 4'd10;

    logic [3:0]        state;
    logic [ADDR_W-1:0] chunk;
    logic [ACC_W-1:0]  acc_r, acc_g, acc_b;
    logic [7:0]        exp_r, exp_g, exp_b;
    logic [17:0]       thr_q;
    logic [7:0]        bg_r, bg_g, bg_b;
    logic [PW-1:0]     in_r, in_g, in_b;
    logic [WD_W-1:0]   wd_cnt;
    logic              err_q;
    logic              start_sum_q, start_bg_q;

    logic last_chunk, wd_expired, sum_ack, bg_ack, bg_write;

    // Decode of the handshake events; a done on the expiry cycle still counts as done
    always_comb begin
        last_chunk = (chunk == ADDR_W'(NUM_CHUNKS - 1));
        wd_expired = (wd_cnt == WD_W'(WAIT_LIMIT - 1));
        sum_ack    = (state == S_WAIT) && (bus.pe_Qsd || wd_expired);
        bg_ack     = (state == B_WAIT) && (bus.pe_Qbgd || wd_expired);
        bg_write   = (state == B_WAIT) && bus.pe_Qbgd;
    end

    assign Busy = (state != IDLE);
    assign Done = (state == FINISH);
    assign Err  = err_q;

    assign bus.mem_rd_addr     = chunk;
    assign bus.mem_wr_en       = bg_write;
    assign bus.mem_wr_addr     = bg_write ? chunk : '0;
    assign bus.mem_wr_r        = bg_write ? bus.pe_red_out   : '0;
    assign bus.mem_wr_g        = bg_write ? bus.pe_green_out : '0;
    assign bus.mem_wr_b        = bg_write ? bus.pe_blue_out  : '0;
    assign bus.pe_red_in       = in_r;
    assign bus.pe_green_in     = in_g;
    assign bus.pe_blue_in      = in_b;
    assign bus.pe_red_exp      = exp_r;
    assign bus.pe_green_exp    = exp_g;
    assign bus.pe_blue_exp     = exp_b;
    assign bus.pe_threshold    = thr_q;
    assign bus.pe_desired_bg_r = bg_r;
    assign bus.pe_desired_bg_g = bg_g;
    assign bus.pe_desired_bg_b = bg_b;
    assign bus.Start_Sum       = start_sum_q;
    assign bus.Start_BgRemoval = start_bg_q;
    assign bus.Ack             = sum_ack || bg_ack;

    // Frame sequencer: sum pass, mean, removal pass; start pulses are registered so they line up with pe_*_in
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            chunk       <= '0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            exp_r       <= '0;
            exp_g       <= '0;
            exp_b       <= '0;
            thr_q       <= '0;
            bg_r        <= '0;
            bg_g        <= '0;
            bg_b        <= '0;
            in_r        <= '0;
            in_g        <= '0;
            in_b        <= '0;
            wd_cnt      <= '0;
            err_q       <= 1'b0;
            start_sum_q <= 1'b0;
            start_bg_q  <= 1'b0;
        end else begin
            start_sum_q <= 1'b0;
            start_bg_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        chunk <= '0;
                        acc_r <= '0;
                        acc_g <= '0;
                        acc_b <= '0;
                        err_q <= 1'b0;
                        thr_q <= threshold;
                        bg_r  <= desired_bg_r;
                        bg_g  <= desired_bg_g;
                        bg_b  <= desired_bg_b;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: if (bus.pe_Qi) state <= S_LOAD;
                S_LOAD: begin
                    in_r        <= bus.mem_rd_r;
                    in_g        <= bus.mem_rd_g;
                    in_b        <= bus.mem_rd_b;
                    start_sum_q <= 1'b1;
                    wd_cnt      <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.pe_Qsd) begin
                        acc_r <= acc_r + ACC_W'(bus.pe_red_sum);
                        acc_g <= acc_g + ACC_W'(bus.pe_green_sum);
                        acc_b <= acc_b + ACC_W'(bus.pe_blue_sum);
                        state <= S_NEXT;
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_NEXT: begin
                    if (last_chunk) begin
                        state <= MEAN;
                    end else begin
                        chunk <= chunk + ADDR_W'(1);
                        state <= S_FETCH;
                    end
                end
                MEAN: begin
                    exp_r <= 8'(acc_r >> LOG2_TOTAL);
                    exp_g <= 8'(acc_g >> LOG2_TOTAL);
                    exp_b <= 8'(acc_b >> LOG2_TOTAL);
                    chunk <= '0;
                    state <= B_FETCH;
                end
                B_FETCH: if (bus.pe_Qi) state <= B_LOAD;
                B_LOAD: begin
                    in_r       <= bus.mem_rd_r;
                    in_g       <= bus.mem_rd_g;
                    in_b       <= bus.mem_rd_b;
                    start_bg_q <= 1'b1;
                    wd_cnt     <= '0;
                    state      <= B_WAIT;
                end
                B_WAIT: begin
                    if (bus.pe_Qbgd) begin
                        state <= B_NEXT;
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                B_NEXT: begin
                    if (last_chunk) begin
                        state <= FINISH;
                    end else begin
                        chunk <= chunk + ADDR_W'(1);
                        state <= B_FETCH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_frame_controller.sv
// tb/tb_pe_frame_controller.sv - scoreboard bench for pe_frame_controller with behavioural pe and frame buffer
module tb_pe_frame_controller;
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [17:0] threshold = '0;
    logic [7:0]  desired_bg_r = '0, desired_bg_g = '0, desired_bg_b = '0;
    logic        Busy, Done, Err;

    pe_frame_controller_if #(.NUM_PIXELS(1), .ADDR_W(4)) bus ();

    pe_frame_controller #(
        .NUM_PIXELS(1), .NUM_CHUNKS(16), .ADDR_W(4),
        .LOG2_TOTAL(4), .ACC_W(12), .WAIT_LIMIT(64)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .threshold(threshold),
        .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
        .Busy(Busy), .Done(Done), .Err(Err), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // frame buffer: synchronous read, writes logged as they commit
    logic [7:0] fr_r [16];
    logic [7:0] fr_g [16];
    logic [7:0] fr_b [16];
    logic [7:0] rd_r = '0, rd_g = '0, rd_b = '0;
    wr_t exp_q [$];
    wr_t act_q [$];

    always @(posedge Clk) begin
        rd_r <= fr_r[bus.mem_rd_addr];
        rd_g <= fr_g[bus.mem_rd_addr];
        rd_b <= fr_b[bus.mem_rd_addr];
        if (bus.mem_wr_en)
            act_q.push_back({bus.mem_wr_addr, bus.mem_wr_r, bus.mem_wr_g, bus.mem_wr_b});
    end
    assign bus.mem_rd_r = rd_r;
    assign bus.mem_rd_g = rd_g;
    assign bus.mem_rd_b = rd_b;

    // behavioural pe: fixed latency, holds done until Ack; pe_hang suppresses sum-done
    logic       pe_busy = 1'b0, pe_bgm = 1'b0, pe_qsd = 1'b0, pe_qbgd = 1'b0, pe_hang = 1'b0;
    int         pe_cnt = 0;
    logic [7:0] pl_r = '0, pl_g = '0, pl_b = '0;
    int         pe_d2;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pe_busy <= 1'b0;
            pe_qsd  <= 1'b0;
            pe_qbgd <= 1'b0;
            pe_cnt  <= 0;
        end else if (!pe_busy) begin
            if (bus.Start_Sum || bus.Start_BgRemoval) begin
                pe_busy <= 1'b1;
                pe_bgm  <= bus.Start_BgRemoval;
                pe_cnt  <= 2;
                pl_r    <= bus.pe_red_in;
                pl_g    <= bus.pe_green_in;
                pl_b    <= bus.pe_blue_in;
            end
        end else if (bus.Ack) begin
            pe_busy <= 1'b0;
            pe_qsd  <= 1'b0;
            pe_qbgd <= 1'b0;
        end else if (pe_cnt > 0) begin
            pe_cnt <= pe_cnt - 1;
        end else if (pe_bgm) begin
            pe_qbgd <= 1'b1;
        end else if (!pe_hang) begin
            pe_qsd <= 1'b1;
        end
    end

    assign pe_d2 = (int'(pl_r) - int'(bus.pe_red_exp))   * (int'(pl_r) - int'(bus.pe_red_exp))
                 + (int'(pl_g) - int'(bus.pe_green_exp)) * (int'(pl_g) - int'(bus.pe_green_exp))
                 + (int'(pl_b) - int'(bus.pe_blue_exp))  * (int'(pl_b) - int'(bus.pe_blue_exp));
    assign bus.pe_Qi        = !pe_busy;
    assign bus.pe_Qsd       = pe_qsd;
    assign bus.pe_Qbgd      = pe_qbgd;
    assign bus.pe_red_sum   = pl_r;
    assign bus.pe_green_sum = pl_g;
    assign bus.pe_blue_sum  = pl_b;
    assign bus.pe_red_out   = (pe_d2 > int'(bus.pe_threshold)) ? pl_r : bus.pe_desired_bg_r;
    assign bus.pe_green_out = (pe_d2 > int'(bus.pe_threshold)) ? pl_g : bus.pe_desired_bg_g;
    assign bus.pe_blue_out  = (pe_d2 > int'(bus.pe_threshold)) ? pl_b : bus.pe_desired_bg_b;

    // event monitor, sampled mid-cycle
    int cyc = 0, n_ss = 0, n_bg = 0, n_ack = 0, n_done = 0, ss_cyc = 0, ack_cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (bus.Start_Sum) begin n_ss++; ss_cyc = cyc; end
        if (bus.Start_BgRemoval) n_bg++;
        if (bus.Ack) begin n_ack++; ack_cyc = cyc; end
        if (Done) n_done++;
    end

    int em_r, em_g, em_b;

    // mean of the loaded frame and the write-back it should produce
    task automatic build_expected();
        int sr = 0, sg = 0, sb = 0, d2;
        for (int i = 0; i < 16; i++) begin
            sr += fr_r[i]; sg += fr_g[i]; sb += fr_b[i];
        end
        em_r = sr / 16; em_g = sg / 16; em_b = sb / 16;
        for (int i = 0; i < 16; i++) begin
            d2 = (fr_r[i] - em_r) * (fr_r[i] - em_r) + (fr_g[i] - em_g) * (fr_g[i] - em_g)
               + (fr_b[i] - em_b) * (fr_b[i] - em_b);
            if (d2 > int'(threshold)) exp_q.push_back({4'(i), fr_r[i], fr_g[i], fr_b[i]});
            else exp_q.push_back({4'(i), desired_bg_r, desired_bg_g, desired_bg_b});
        end
    endtask

    task automatic clear_logs();
        @(posedge Clk);
        n_ss = 0; n_bg = 0; n_ack = 0; n_done = 0;
        exp_q.delete(); act_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (Done) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        pulse_start();
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if ({Done, Err, bus.mem_wr_en, bus.Ack, bus.Start_Sum, bus.Start_BgRemoval} !== 6'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000000",
                {Done, Err, bus.mem_wr_en, bus.Ack, bus.Start_Sum, bus.Start_BgRemoval});
        end
        n_cmp++; if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_r} !== 16'h0) begin
            n_bad++; $display("FAIL reset_mem: got %h want 0", {bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_r});
        end
        n_cmp++; if ({bus.pe_red_in, bus.pe_red_exp, bus.pe_threshold, bus.pe_desired_bg_r} !== 42'h0) begin
            n_bad++; $display("FAIL reset_pe_regs: got %h want 0",
                {bus.pe_red_in, bus.pe_red_exp, bus.pe_threshold, bus.pe_desired_bg_r});
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: busy %b want 0", Busy); end
    endtask

    task automatic test_uniform();
        bit to;
        wr_t e, a;
        for (int i = 0; i < 16; i++) begin fr_r[i] = 40; fr_g[i] = 80; fr_b[i] = 120; end
        threshold = 18'd100; desired_bg_r = 1; desired_bg_g = 2; desired_bg_b = 3;
        clear_logs();
        build_expected();
        pulse_start();
        wait_done(to);
        repeat (3) @(negedge Clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL uniform_timeout: no Done within bound"); end
        n_cmp++; if ({bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp} !== {8'd40, 8'd80, 8'd120}) begin
            n_bad++; $display("FAIL uniform_exp: got %0d,%0d,%0d want 40,80,120",
                bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp);
        end
        n_cmp++; if (n_ss != 16) begin n_bad++; $display("FAIL uniform_start_sum: got %0d want 16", n_ss); end
        n_cmp++; if (n_bg != 16) begin n_bad++; $display("FAIL uniform_start_bg: got %0d want 16", n_bg); end
        n_cmp++; if (n_ack != 32) begin n_bad++; $display("FAIL uniform_acks: got %0d want 32", n_ack); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL uniform_done: got %0d want 1", n_done); end
        n_cmp++; if (Err !== 1'b0) begin n_bad++; $display("FAIL uniform_err: got %b want 0", Err); end
        n_cmp++; if (act_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL uniform_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL uniform_write: got %h want %h", a, e); end
        end
    endtask

    task automatic test_outlier();
        bit to;
        wr_t e, a;
        for (int i = 0; i < 16; i++) begin
            fr_r[i] = (i == 9) ? 8'd255 : 8'd0;
            fr_g[i] = 8'($urandom_range(0, 255));
            fr_b[i] = 8'($urandom_range(0, 255));
        end
        threshold = 18'd2000; desired_bg_r = 200; desired_bg_g = 10; desired_bg_b = 90;
        clear_logs();
        build_expected();
        pulse_start();
        wait_done(to);
        repeat (2) @(negedge Clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL outlier_timeout: no Done within bound"); end
        n_cmp++; if (bus.pe_red_exp !== 8'd15) begin
            n_bad++; $display("FAIL outlier_red_exp: got %0d want 15", bus.pe_red_exp);
        end
        n_cmp++; if ({bus.pe_green_exp, bus.pe_blue_exp} !== {8'(em_g), 8'(em_b)}) begin
            n_bad++; $display("FAIL outlier_gb_exp: got %0d,%0d want %0d,%0d",
                bus.pe_green_exp, bus.pe_blue_exp, em_g, em_b);
        end
        n_cmp++; if (act_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL outlier_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL outlier_write: got %h want %h", a, e); end
        end
    endtask

    task automatic test_timeout();
        bit to;
        pe_hang = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(to);
        pe_hang = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL timeout_no_done: no Done within bound"); end
        n_cmp++; if (Err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", Err); end
        n_cmp++; if (n_ack != 1) begin n_bad++; $display("FAIL timeout_acks: got %0d want 1", n_ack); end
        n_cmp++; if (ack_cyc - ss_cyc != 63) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want 63", ack_cyc - ss_cyc);
        end
        n_cmp++; if (n_bg != 0) begin n_bad++; $display("FAIL timeout_no_mean: bg starts %0d want 0", n_bg); end
        n_cmp++; if (act_q.size() != 0) begin n_bad++; $display("FAIL timeout_writes: got %0d want 0", act_q.size()); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL timeout_done: got %0d want 1", n_done); end
        n_cmp++; if ({Busy, Err} !== 2'b01) begin n_bad++; $display("FAIL timeout_err_held: got %b want 01", {Busy, Err}); end
    endtask

    task automatic test_bwait_and_reset();
        bit to, seen;
        int k;
        wr_t e, a;
        for (int i = 0; i < 16; i++) begin
            fr_r[i] = 8'($urandom_range(0, 255)); fr_g[i] = 8'($urandom_range(0, 255)); fr_b[i] = 8'($urandom_range(0, 255));
        end
        threshold = 18'd6000; desired_bg_r = 7; desired_bg_g = 7; desired_bg_b = 7;
        clear_logs();
        build_expected();
        pulse_start();
        k = 0;
        for (int i = 0; i < 1000 && k < 3; i++) begin
            @(negedge Clk);
            if (bus.Start_BgRemoval) k++;
        end
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL bwait_start_busy: got %b want 1", Busy); end
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (bus.mem_wr_en && bus.mem_wr_addr == 4'd5) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bwait_chunk5: write of chunk 5 never offered"); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if ({bus.mem_wr_en, Busy, bus.Ack} !== 3'b000) begin
            n_bad++; $display("FAIL reset_mid_frame: wr_en/busy/ack got %b want 000", {bus.mem_wr_en, Busy, bus.Ack});
        end
        @(negedge Clk); Reset = 1'b0;
        n_cmp++; if (n_ss != 16) begin n_bad++; $display("FAIL bwait_start_ignored: sum starts %0d want 16", n_ss); end
        n_cmp++; if (act_q.size() != 5) begin n_bad++; $display("FAIL reset_wr_count: got %0d want 5", act_q.size()); end
        while (act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL reset_partial_write: got %h want %h", a, e); end
        end
        for (int i = 0; i < 16; i++) begin
            fr_r[i] = 8'(30 + i); fr_g[i] = 8'(200 - i); fr_b[i] = 8'(i * 9);
        end
        threshold = 18'd150;
        clear_logs();
        build_expected();
        pulse_start();
        n_cmp++; if ({Busy, bus.mem_rd_addr} !== 5'b1_0000) begin
            n_bad++; $display("FAIL restart_addr: busy/addr got %b want 10000", {Busy, bus.mem_rd_addr});
        end
        wait_done(to);
        repeat (2) @(negedge Clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL restart_timeout: no Done within bound"); end
        n_cmp++; if ({bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp, Err} !== {8'(em_r), 8'(em_g), 8'(em_b), 1'b0}) begin
            n_bad++; $display("FAIL restart_exp: got %0d,%0d,%0d err %b want %0d,%0d,%0d err 0",
                bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp, Err, em_r, em_g, em_b);
        end
        n_cmp++; if (act_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL restart_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL restart_write: got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        wr_t e, a;
        for (int i = 0; i < 16; i++) begin fr_r[i] = 100; fr_g[i] = 100; fr_b[i] = 100; end
        fr_r[3] = 250;
        threshold = 18'd50; desired_bg_r = 0; desired_bg_g = 255; desired_bg_b = 0;
        clear_logs();
        build_expected();
        pulse_start();
        wait_done(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_first_timeout: no Done within bound"); end
        for (int i = 0; i < 16; i++) begin fr_r[i] = 8'(i * 16); fr_g[i] = 8'(255 - i * 3); fr_b[i] = 8'(60); end
        build_expected();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy %b want 1", Busy); end
        wait_done(to);
        repeat (2) @(negedge Clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_second_timeout: no Done within bound"); end
        n_cmp++; if ({bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp} !== {8'(em_r), 8'(em_g), 8'(em_b)}) begin
            n_bad++; $display("FAIL b2b_exp: got %0d,%0d,%0d want %0d,%0d,%0d",
                bus.pe_red_exp, bus.pe_green_exp, bus.pe_blue_exp, em_r, em_g, em_b);
        end
        n_cmp++; if (n_done != 2) begin n_bad++; $display("FAIL b2b_done: got %0d want 2", n_done); end
        n_cmp++; if (act_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL b2b_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL b2b_write: got %h want %h", a, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin fr_r[i] = 0; fr_g[i] = 0; fr_b[i] = 0; end
        test_reset();
        test_uniform();
        test_outlier();
        test_timeout();
        test_bwait_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
